// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar scan sequencer and its position counter.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESPERA         = 4'd1,
        MEDIR          = 4'd2,
        AGUARDA        = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_SERIAL = 4'd5,
        PROXIMA        = 4'd6,
        REPETE         = 4'd7
    } estado_t;

    localparam logic MODO_CIRCULAR = 1'b0;
    localparam logic MODO_VAIVEM   = 1'b1;

    localparam int SENTINELA_MAX_W = 64;

    // Widest all-ones word; users narrow it to their measurement width with a cast.
    function automatic logic [SENTINELA_MAX_W-1:0] SENTINELA();
        return '1;
    endfunction

endpackage

// File: rtl/sonar_varredura_if.sv
// Bus between the scan sequencer (master) and its sensor, serial and servo peers (slave).
interface sonar_varredura_if #(
    parameter int MEDIDA_W = 12,
    parameter int POS_W    = 3
);
    logic                ligar;
    logic                modo;
    logic                medida_pronta;
    logic [MEDIDA_W-1:0] medida;
    logic                serial_pronto;
    logic                medir;
    logic                enviar;
    logic [MEDIDA_W-1:0] dados;
    logic [POS_W-1:0]    posicao;
    logic [MEDIDA_W-1:0] dist_min;
    logic [POS_W-1:0]    pos_min;
    logic                fim_varredura;
    logic                erro_timeout;
    logic [3:0]          db_estado;

    modport master (
        input  ligar, modo, medida_pronta, medida, serial_pronto,
        output medir, enviar, dados, posicao, dist_min, pos_min,
               fim_varredura, erro_timeout, db_estado
    );

    modport slave (
        output ligar, modo, medida_pronta, medida, serial_pronto,
        input  medir, enviar, dados, posicao, dist_min, pos_min,
               fim_varredura, erro_timeout, db_estado
    );
endinterface

// File: rtl/sonar_posicao.sv
// Servo position counter: wrap or ping-pong stepping, plus the "leaving last endpoint" flag.
module sonar_posicao
    import sonar_pkg::*;
#(
    parameter int N_POS = 8,
    parameter int POS_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             avanca,
    input  logic             modo,
    output logic [POS_W-1:0] posicao,
    output logic             fim
);
    localparam logic [POS_W-1:0] ULTIMA = POS_W'(N_POS - 1);
    localparam logic [POS_W-1:0] UM     = POS_W'(1);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             sobe_q, sobe_d;

    // fim reflects the current position and mode; the caller qualifies it with avanca.
    always_comb begin
        pos_d  = pos_q;
        sobe_d = sobe_q;
        fim    = 1'b0;
        if (modo == MODO_CIRCULAR) begin
            fim = (pos_q == ULTIMA);
            if (avanca) begin
                sobe_d = 1'b1;
                pos_d  = fim ? '0 : pos_q + UM;
            end
        end else if (sobe_q) begin
            fim = (pos_q == ULTIMA);
            if (avanca) begin
                sobe_d = ~fim;
                pos_d  = fim ? pos_q - UM : pos_q + UM;
            end
        end else begin
            fim = (pos_q == '0);
            if (avanca) begin
                sobe_d = fim;
                pos_d  = fim ? pos_q + UM : pos_q - UM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_q  <= '0;
            sobe_q <= 1'b1;
        end else begin
            pos_q  <= pos_d;
            sobe_q <= sobe_d;
        end
    end

    assign posicao = pos_q;

endmodule

// File: rtl/sonar_varredura.sv
// Sonar scan sequencer: settle, measure, transmit, advance; tracks the per-sweep minimum.
// Define SONAR_REPETE_EN to retry a timed-out measurement once before flagging the error.
module sonar_varredura
    import sonar_pkg::*;
#(
    parameter int N_POS     = 8,
    parameter int POS_W     = 3,
    parameter int MEDIDA_W  = 12,
    parameter int T_ESPERA  = 100000000,
    parameter int T_TIMEOUT = 3000000
) (
    input  logic              clock,
    input  logic              reset,
    sonar_varredura_if.master bus
);
    localparam int T_MAX = (T_ESPERA > T_TIMEOUT) ? T_ESPERA : T_TIMEOUT;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TMR_W-1:0]    FIM_ESPERA  = TMR_W'(T_ESPERA - 1);
    localparam logic [TMR_W-1:0]    FIM_TIMEOUT = TMR_W'(T_TIMEOUT - 1);
    localparam logic [MEDIDA_W-1:0] SENT        = MEDIDA_W'(SENTINELA());

    estado_t             estado_q, estado_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [MEDIDA_W-1:0] dados_q, dados_d;
    logic [MEDIDA_W-1:0] dist_q, dist_d;
    logic [POS_W-1:0]    pmin_q, pmin_d;
    logic [MEDIDA_W-1:0] min_q, min_d;
    logic [POS_W-1:0]    pmin_run_q, pmin_run_d;
    logic                erro_q, erro_d;
`ifdef SONAR_REPETE_EN
    logic                repete_q, repete_d;
`endif

    logic                avanca, fim_pos;
    logic [POS_W-1:0]    posicao;
    logic [MEDIDA_W-1:0] cand_min;
    logic [POS_W-1:0]    cand_pos;

    assign avanca = (estado_q == PROXIMA);

    sonar_posicao #(
        .N_POS (N_POS),
        .POS_W (POS_W)
    ) u_posicao (
        .clock   (clock),
        .reset   (reset),
        .avanca  (avanca),
        .modo    (bus.modo),
        .posicao (posicao),
        .fim     (fim_pos)
    );

    always_comb begin
        estado_d   = estado_q;
        dados_d    = dados_q;
        dist_d     = dist_q;
        pmin_d     = pmin_q;
        min_d      = min_q;
        pmin_run_d = pmin_run_q;
        erro_d     = erro_q;
`ifdef SONAR_REPETE_EN
        repete_d   = repete_q;
`endif
        // Running minimum including the value just transmitted; strict < keeps the first tie.
        cand_min = min_q;
        cand_pos = pmin_run_q;
        if ((dados_q != SENT) && (dados_q < min_q)) begin
            cand_min = dados_q;
            cand_pos = posicao;
        end

        unique case (estado_q)
            INICIAL: if (bus.ligar) estado_d = ESPERA;
            ESPERA:  if (tmr_q == FIM_ESPERA) estado_d = MEDIR;
            MEDIR:   estado_d = AGUARDA;
            AGUARDA: begin
                if (bus.medida_pronta) begin
                    dados_d  = bus.medida;
                    estado_d = TRANSMITE;
                end else if (tmr_q == FIM_TIMEOUT) begin
`ifdef SONAR_REPETE_EN
                    if (!repete_q) begin
                        repete_d = 1'b1;
                        estado_d = REPETE;
                    end else begin
                        dados_d  = SENT;
                        erro_d   = 1'b1;
                        estado_d = TRANSMITE;
                    end
`else
                    dados_d  = SENT;
                    erro_d   = 1'b1;
                    estado_d = TRANSMITE;
`endif
                end
            end
            TRANSMITE:      estado_d = AGUARDA_SERIAL;
            AGUARDA_SERIAL: if (bus.serial_pronto) estado_d = PROXIMA;
            PROXIMA: begin
                if (fim_pos) begin
                    dist_d     = cand_min;
                    pmin_d     = cand_pos;
                    min_d      = SENT;
                    pmin_run_d = '0;
                end else begin
                    min_d      = cand_min;
                    pmin_run_d = cand_pos;
                end
`ifdef SONAR_REPETE_EN
                repete_d = 1'b0;
`endif
                estado_d = bus.ligar ? ESPERA : INICIAL;
            end
`ifdef SONAR_REPETE_EN
            REPETE:  estado_d = MEDIR;
`endif
            default: estado_d = INICIAL;
        endcase

        tmr_d = (estado_d != estado_q) ? '0 : tmr_q + TMR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            tmr_q      <= '0;
            dados_q    <= '0;
            dist_q     <= SENT;
            pmin_q     <= '0;
            min_q      <= SENT;
            pmin_run_q <= '0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            tmr_q      <= tmr_d;
            dados_q    <= dados_d;
            dist_q     <= dist_d;
            pmin_q     <= pmin_d;
            min_q      <= min_d;
            pmin_run_q <= pmin_run_d;
            erro_q     <= erro_d;
        end
    end

`ifdef SONAR_REPETE_EN
    always_ff @(posedge clock) begin
        if (!reset) repete_q <= 1'b0;
        else        repete_q <= repete_d;
    end
`endif

    assign bus.medir         = (estado_q == MEDIR);
    assign bus.enviar        = (estado_q == TRANSMITE);
    assign bus.fim_varredura = avanca && fim_pos;
    assign bus.dados         = dados_q;
    assign bus.posicao       = posicao;
    assign bus.dist_min      = dist_q;
    assign bus.pos_min       = pmin_q;
    assign bus.erro_timeout  = erro_q;
    assign bus.db_estado     = estado_q;

endmodule

// File: tb/tb_sonar_varredura.sv
// Directed bench for sonar_varredura with N_POS=4, T_ESPERA=5, T_TIMEOUT=20.
module tb_sonar_varredura;

    localparam int MW = 12;
    localparam int PW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    sonar_varredura_if #(.MEDIDA_W(MW), .POS_W(PW)) s();

    sonar_varredura #(
        .N_POS     (4),
        .POS_W     (PW),
        .MEDIDA_W  (MW),
        .T_ESPERA  (5),
        .T_TIMEOUT (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (s.master)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int ans;   // 1: sensor answers at cycle dly after medir
        int val;
        int dly;
        int modo;
        int pos;   // expected posicao at medir
        int dados;
        int fim;
        int env;   // cycles from medir to enviar
        int dmin;  // dist_min / pos_min after this position's advance
        int pmin;
        int erro;
        int rep;   // retries seen (extra medir pulses and REPETE cycles)
    } row_t;

    row_t rows[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return s.medir;
            1:       return s.enviar;
            default: return s.db_estado == 4'd1;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string tag, output int n);
        n = 0;
        while (!pick(sel) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!pick(sel)) check({tag, "_never_seen"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_estado"},   32'(s.db_estado),     32'd0);
        check({tag, "_medir"},    32'(s.medir),         32'd0);
        check({tag, "_enviar"},   32'(s.enviar),        32'd0);
        check({tag, "_dados"},    32'(s.dados),         32'd0);
        check({tag, "_posicao"},  32'(s.posicao),       32'd0);
        check({tag, "_dist_min"}, 32'(s.dist_min),      32'hFFF);
        check({tag, "_pos_min"},  32'(s.pos_min),       32'd0);
        check({tag, "_fim"},      32'(s.fim_varredura), 32'd0);
        check({tag, "_erro"},     32'(s.erro_timeout),  32'd0);
    endtask

    // Entered on the first negedge of ESPERA; returns on the first negedge of the next ESPERA.
    task automatic run_row(input int k, input row_t r);
        int esp_n, env_n, med_n, rep_n;
        s.modo = (r.modo != 0);
        wait_sig(0, $sformatf("r%0d_medir", k), esp_n);
        check($sformatf("r%0d_espera_cycles", k), esp_n, 5);
        check($sformatf("r%0d_posicao", k), 32'(s.posicao), r.pos);
        env_n = 0;
        med_n = 0;
        rep_n = 0;
        while (!s.enviar && env_n < 100) begin
            @(negedge clock);
            env_n++;
            s.medida_pronta = (r.ans != 0) && (env_n == r.dly);
            s.medida        = 12'(r.val);
            if (s.medir) med_n++;
            if (s.db_estado == 4'd7) rep_n++;
        end
        s.medida_pronta = 1'b0;
        check($sformatf("r%0d_enviar_cycles", k), env_n, r.env);
        check($sformatf("r%0d_dados", k), 32'(s.dados), r.dados);
        check($sformatf("r%0d_medir_retry", k), med_n, r.rep);
        check($sformatf("r%0d_repete_state", k), rep_n, r.rep);
        @(negedge clock);
        s.serial_pronto = 1'b1;
        check($sformatf("r%0d_dados_stable", k), 32'(s.dados), r.dados);
        @(negedge clock);
        s.serial_pronto = 1'b0;
        check($sformatf("r%0d_fim", k), 32'(s.fim_varredura), r.fim);
        @(negedge clock);
        check($sformatf("r%0d_dist_min", k), 32'(s.dist_min), r.dmin);
        check($sformatf("r%0d_pos_min", k), 32'(s.pos_min), r.pmin);
        check($sformatf("r%0d_erro", k), 32'(s.erro_timeout), r.erro);
        $display("pos %0d: dados=%03h fim=%0d dist_min=%03h pos_min=%0d erro=%0d",
                 r.pos, s.dados, r.fim, s.dist_min, s.pos_min, s.erro_timeout);
    endtask

    initial begin
        int n;
        s.ligar = 1'b1;
        s.modo = 1'b0;
        s.medida_pronta = 1'b0;
        s.medida = '0;
        s.serial_pronto = 1'b0;

        // ans val dly modo | pos dados fim env dmin pmin erro rep
        rows.push_back('{1, 'h150,  1, 0, 0, 'h150, 0,  2, 'hFFF, 0, 0, 0});
        rows.push_back('{1, 'h087,  1, 0, 1, 'h087, 0,  2, 'hFFF, 0, 0, 0});
        rows.push_back('{1, 'h230,  1, 0, 2, 'h230, 0,  2, 'hFFF, 0, 0, 0});
        rows.push_back('{1, 'h087,  1, 0, 3, 'h087, 1,  2, 'h087, 1, 0, 0});
        rows.push_back('{1, 'h300,  1, 1, 0, 'h300, 0,  2, 'h087, 1, 0, 0});
        rows.push_back('{1, 'h250,  1, 1, 1, 'h250, 0,  2, 'h087, 1, 0, 0});
        rows.push_back('{1, 'h120,  1, 1, 2, 'h120, 0,  2, 'h087, 1, 0, 0});
        rows.push_back('{1, 'h400,  1, 1, 3, 'h400, 1,  2, 'h120, 2, 0, 0});
        rows.push_back('{1, 'h099,  1, 1, 2, 'h099, 0,  2, 'h120, 2, 0, 0});
        rows.push_back('{1, 'h099,  1, 1, 1, 'h099, 0,  2, 'h120, 2, 0, 0});
        rows.push_back('{1, 'h500,  1, 1, 0, 'h500, 1,  2, 'h099, 2, 0, 0});
        rows.push_back('{1, 'h111,  1, 1, 1, 'h111, 0,  2, 'h099, 2, 0, 0});
        rows.push_back('{1, 'h321, 20, 0, 2, 'h321, 0, 21, 'h099, 2, 0, 0});
        rows.push_back('{1, 'h200,  1, 0, 3, 'h200, 1,  2, 'h111, 1, 0, 0});
        rows.push_back('{1, 'h050,  1, 0, 0, 'h050, 0,  2, 'h111, 1, 0, 0});
        rows.push_back('{1, 'h040,  1, 0, 1, 'h040, 0,  2, 'h111, 1, 0, 0});
`ifdef SONAR_REPETE_EN
        rows.push_back('{1, 'h042, 23, 0, 2, 'h042, 0, 24, 'h111, 1, 0, 1});
        rows.push_back('{0, 'h000,  0, 0, 3, 'hFFF, 1, 43, 'h040, 1, 1, 1});
`else
        rows.push_back('{0, 'h000,  0, 0, 2, 'hFFF, 0, 21, 'h111, 1, 1, 0});
        rows.push_back('{1, 'h060,  1, 0, 3, 'h060, 1,  2, 'h040, 1, 1, 0});
`endif

        repeat (3) @(negedge clock);
        chk_reset("reset");
        reset = 1'b1;
        @(negedge clock);
        check("start_espera", 32'(s.db_estado), 32'd1);

        for (int i = 0; i < rows.size(); i++) run_row(i, rows[i]);

        // Reset while waiting for the serial transmitter; its late pulse must be ignored.
        wait_sig(0, "rst_medir", n);
        check("rst_posicao", 32'(s.posicao), 32'd0);
        @(negedge clock);
        s.medida_pronta = 1'b1;
        s.medida = 12'h777;
        @(negedge clock);
        s.medida_pronta = 1'b0;
        check("rst_enviar", 32'(s.enviar), 32'd1);
        @(negedge clock);
        check("rst_in_serial", 32'(s.db_estado), 32'd5);
        reset = 1'b0;
        @(negedge clock);
        chk_reset("midrun_reset");
        reset = 1'b1;
        @(negedge clock);
        check("rst_espera", 32'(s.db_estado), 32'd1);
        s.serial_pronto = 1'b1;
        @(negedge clock);
        s.serial_pronto = 1'b0;
        check("late_pronto_ignored", 32'(s.db_estado), 32'd1);
        wait_sig(0, "post_rst_medir", n);
        check("post_rst_espera_cycles", n, 4);
        check("post_rst_posicao", 32'(s.posicao), 32'd0);
        $display("reset during AGUARDA_SERIAL: late serial_pronto ignored, posicao=%0d", s.posicao);

        // Drop ligar mid-position: the position completes, advances, then the block idles.
        s.ligar = 1'b0;
        @(negedge clock);
        s.medida_pronta = 1'b1;
        s.medida = 12'h010;
        @(negedge clock);
        s.medida_pronta = 1'b0;
        check("stop_enviar", 32'(s.enviar), 32'd1);
        @(negedge clock);
        s.serial_pronto = 1'b1;
        @(negedge clock);
        s.serial_pronto = 1'b0;
        check("stop_proxima", 32'(s.db_estado), 32'd6);
        @(negedge clock);
        check("stop_inicial", 32'(s.db_estado), 32'd0);
        check("stop_posicao", 32'(s.posicao), 32'd1);
        repeat (3) @(negedge clock);
        check("idle_estado", 32'(s.db_estado), 32'd0);
        check("idle_posicao", 32'(s.posicao), 32'd1);
        check("idle_medir", 32'(s.medir), 32'd0);
        check("idle_dist_min", 32'(s.dist_min), 32'hFFF);
        $display("ligar=0: stopped in INICIAL at posicao=%0d", s.posicao);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
